// File: rtl/game_pkg.sv
// Shared state codes and BCD constants for the game countdown controller.
package game_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit MM:SS BCD register with load, one-second decrement and minute increment,
// plus zero / one-second / warning-window compares on the held value.
module bcd_mmss_counter
    import game_pkg::*;
#(
    parameter int INIT_MIN = 2,
    parameter int INIT_SEC = 0,
    parameter int WARN_SEC = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic             inc_min,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             is_zero,
    output logic             is_one,
    output logic             at_warn
);

    localparam logic [BCD_W-1:0] INIT_MT = BCD_W'(INIT_MIN / 10);
    localparam logic [BCD_W-1:0] INIT_MO = BCD_W'(INIT_MIN % 10);
    localparam logic [BCD_W-1:0] INIT_ST = BCD_W'(INIT_SEC / 10);
    localparam logic [BCD_W-1:0] INIT_SO = BCD_W'(INIT_SEC % 10);
    localparam logic [6:0]       WARN_V  = 7'(WARN_SEC);

    logic [BCD_W-1:0] min_tens_reg, min_ones_reg, sec_tens_reg, sec_ones_reg;
    logic             min_zero;
    logic [6:0]       sec_val;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            min_tens_reg <= INIT_MT;
            min_ones_reg <= INIT_MO;
            sec_tens_reg <= INIT_ST;
            sec_ones_reg <= INIT_SO;
        end else if (dec) begin
            // Borrow ripples seconds -> tens of seconds -> minutes; caller never decrements 00:00.
            if (sec_ones_reg != '0) begin
                sec_ones_reg <= sec_ones_reg - 1'b1;
            end else begin
                sec_ones_reg <= BCD_W'(9);
                if (sec_tens_reg != '0) begin
                    sec_tens_reg <= sec_tens_reg - 1'b1;
                end else begin
                    sec_tens_reg <= BCD_W'(SEC_TENS_MAX);
                    if (min_ones_reg != '0) begin
                        min_ones_reg <= min_ones_reg - 1'b1;
                    end else begin
                        min_ones_reg <= BCD_W'(9);
                        min_tens_reg <= min_tens_reg - 1'b1;
                    end
                end
            end
        end else if (inc_min) begin
            if (min_ones_reg == BCD_W'(9)) begin
                min_ones_reg <= '0;
                min_tens_reg <= (min_tens_reg == BCD_W'(9)) ? '0 : min_tens_reg + 1'b1;
            end else begin
                min_ones_reg <= min_ones_reg + 1'b1;
            end
        end
    end

    assign min_tens = min_tens_reg;
    assign min_ones = min_ones_reg;
    assign sec_tens = sec_tens_reg;
    assign sec_ones = sec_ones_reg;

    assign min_zero = (min_tens_reg == '0) && (min_ones_reg == '0);
    assign sec_val  = 7'(sec_tens_reg) * 7'd10 + 7'(sec_ones_reg);
    assign is_zero  = min_zero && (sec_val == 7'd0);
    assign is_one   = min_zero && (sec_val == 7'd1);
    assign at_warn  = min_zero && (sec_val <= WARN_V);

endmodule

// File: rtl/game_countdown_ctrl.sv
// Round countdown sequencer: start/pause/resume/clear FSM around a BCD MM:SS counter,
// with registered running, expiry pulse and blink-driven display blanking.
module game_countdown_ctrl
    import game_pkg::*;
#(
    parameter int INIT_MIN = 2,
    parameter int INIT_SEC = 0,
    parameter int WARN_SEC = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             blink_lvl,
    input  logic             btn_start,
    input  logic             btn_clear,
    input  logic             btn_inc_min,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             digit_blank,
    output logic             running,
    output logic             expired_pulse,
    output logic [1:0]       state_o
);

    state_t state_reg, state_next;
    logic   expired_reg, expired_next;
    logic   running_reg, blank_reg, blank_cond;
    logic   load, dec, inc_en;
    logic   is_zero, is_one, at_warn;

    bcd_mmss_counter #(
        .INIT_MIN (INIT_MIN),
        .INIT_SEC (INIT_SEC),
        .WARN_SEC (WARN_SEC)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dec      (dec),
        .inc_min  (inc_en),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .is_zero  (is_zero),
        .is_one   (is_one),
        .at_warn  (at_warn)
    );

    // Priority: clear > start > tick > inc_min; start and tick combine only in RUN.
    always_comb begin
        state_next   = state_reg;
        expired_next = 1'b0;
        load         = 1'b0;
        dec          = 1'b0;
        inc_en       = 1'b0;
        if (btn_clear) begin
            state_next = ST_IDLE;
            load       = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (btn_start) begin
                        if (!is_zero) state_next = ST_RUN;
                    end else if (btn_inc_min) begin
                        inc_en = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick_1hz) begin
                        dec = 1'b1;
                        if (is_one) begin
                            state_next   = ST_DONE;
                            expired_next = 1'b1;
                        end else if (btn_start) begin
                            state_next = ST_PAUSE;
                        end
                    end else if (btn_start) begin
                        state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (btn_start) state_next = ST_RUN;
                end
                ST_DONE: begin
                    if (btn_start) begin
                        state_next = ST_IDLE;
                        load       = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign blank_cond = (state_reg == ST_PAUSE) || (state_reg == ST_DONE) ||
                        ((state_reg == ST_RUN) && at_warn);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
            blank_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            running_reg <= (state_next == ST_RUN);
            expired_reg <= expired_next;
            blank_reg   <= blink_lvl && blank_cond;
        end
    end

    assign state_o       = state_reg;
    assign running       = running_reg;
    assign expired_pulse = expired_reg;
    assign digit_blank   = blank_reg;

endmodule

// File: tb/tb_game_countdown_ctrl.sv
// Directed bench for game_countdown_ctrl with hand-computed expected digits and flags.
module tb_game_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, blink_lvl, btn_start, btn_clear, btn_inc_min;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       digit_blank, running, expired_pulse;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_countdown_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1hz      (tick_1hz),
        .blink_lvl     (blink_lvl),
        .btn_start     (btn_start),
        .btn_clear     (btn_clear),
        .btn_inc_min   (btn_inc_min),
        .min_tens      (min_tens),
        .min_ones      (min_ones),
        .sec_tens      (sec_tens),
        .sec_ones      (sec_ones),
        .digit_blank   (digit_blank),
        .running       (running),
        .expired_pulse (expired_pulse),
        .state_o       (state_o)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // One clock: drive inputs before the edge, sample 1 time unit after it.
    task automatic step(input logic r, input logic c, input logic s, input logic t, input logic i);
        rst = r; btn_clear = c; btn_start = s; tick_1hz = t; btn_inc_min = i;
        @(posedge clk);
        #1;
        rst = 1'b0; btn_clear = 1'b0; btn_start = 1'b0; tick_1hz = 1'b0; btn_inc_min = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0);
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        rst = 1'b0; tick_1hz = 1'b0; blink_lvl = 1'b0;
        btn_start = 1'b0; btn_clear = 1'b0; btn_inc_min = 1'b0;
        @(negedge clk);

        // 1: reset, start, three ticks
        step(1, 0, 0, 0, 0);
        check("rst_digits", digits(), 16'h0200);
        check("rst_state", 16'(state_o), 16'h0);
        check("rst_running", 16'(running), 16'h0);
        check("rst_expired", 16'(expired_pulse), 16'h0);
        check("rst_blank", 16'(digit_blank), 16'h0);
        step(0, 0, 1, 0, 0);
        check("t1_state_run", 16'(state_o), 16'h1);
        check("t1_running", 16'(running), 16'h1);
        ticks(1); check("t1_0159", digits(), 16'h0159);
        ticks(1); check("t1_0158", digits(), 16'h0158);
        ticks(1); check("t1_0157", digits(), 16'h0157);

        // 2: run down to expiry
        step(0, 1, 0, 0, 0);
        check("t2_clear", digits(), 16'h0200);
        step(0, 0, 1, 0, 0);
        ticks(118);
        check("t2_0002", digits(), 16'h0002);
        ticks(1);
        check("t2_0001", digits(), 16'h0001);
        check("t2_exp_before", 16'(expired_pulse), 16'h0);
        ticks(1);
        check("t2_0000", digits(), 16'h0000);
        check("t2_state_done", 16'(state_o), 16'h3);
        check("t2_exp_high", 16'(expired_pulse), 16'h1);
        check("t2_running_off", 16'(running), 16'h0);
        ticks(1);
        check("t2_exp_low", 16'(expired_pulse), 16'h0);
        ticks(3);
        check("t2_hold", digits(), 16'h0000);
        check("t2_still_done", 16'(state_o), 16'h3);

        // 3: start+tick together pauses after decrement
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(90);
        check("t3_0030", digits(), 16'h0030);
        step(0, 0, 1, 1, 0);
        check("t3_0029", digits(), 16'h0029);
        check("t3_pause", 16'(state_o), 16'h2);
        ticks(5);
        check("t3_frozen", digits(), 16'h0029);
        blink_lvl = 1'b1;
        step(0, 0, 0, 0, 1);
        check("t3_pause_blank", 16'(digit_blank), 16'h1);
        check("t3_inc_ignored", digits(), 16'h0029);
        blink_lvl = 1'b0;
        step(0, 0, 1, 0, 0);
        check("t3_resume", 16'(state_o), 16'h1);

        // 4: minute increment wrap and start refused at 00:00
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 97; k++) step(0, 0, 0, 0, 1);
        check("t4_9900", digits(), 16'h9900);
        step(0, 0, 0, 0, 1);
        check("t4_wrap", digits(), 16'h0000);
        step(0, 0, 1, 0, 0);
        check("t4_no_start", 16'(state_o), 16'h0);
        step(0, 0, 0, 0, 1);
        check("t4_0100", digits(), 16'h0100);
        step(0, 0, 0, 1, 0);
        check("t4_idle_tick", digits(), 16'h0100);

        // 5: warning-window blink
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(109);
        check("t5_0011", digits(), 16'h0011);
        blink_lvl = 1'b1;
        step(0, 0, 0, 0, 0);
        check("t5_no_blank", 16'(digit_blank), 16'h0);
        step(0, 0, 0, 1, 0);
        check("t5_0010", digits(), 16'h0010);
        check("t5_lag", 16'(digit_blank), 16'h0);
        step(0, 0, 0, 0, 0);
        check("t5_blank_hi", 16'(digit_blank), 16'h1);
        blink_lvl = 1'b0;
        step(0, 0, 0, 0, 0);
        check("t5_blank_lo", 16'(digit_blank), 16'h0);
        blink_lvl = 1'b1;
        step(0, 0, 0, 0, 0);
        check("t5_blank_hi2", 16'(digit_blank), 16'h1);
        blink_lvl = 1'b0;

        // 6: reset mid-run with tick, then clear out of DONE, then ack out of DONE
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(60);
        check("t6_0100", digits(), 16'h0100);
        step(1, 0, 0, 1, 0);
        check("t6_rst_digits", digits(), 16'h0200);
        check("t6_rst_state", 16'(state_o), 16'h0);
        check("t6_rst_expired", 16'(expired_pulse), 16'h0);
        check("t6_rst_running", 16'(running), 16'h0);
        step(0, 0, 1, 0, 0);
        ticks(120);
        check("t6_done", 16'(state_o), 16'h3);
        step(0, 1, 0, 0, 0);
        check("t6_clear_state", 16'(state_o), 16'h0);
        check("t6_clear_digits", digits(), 16'h0200);
        step(0, 0, 1, 0, 0);
        ticks(120);
        step(0, 0, 1, 0, 0);
        check("t6_ack_state", 16'(state_o), 16'h0);
        check("t6_ack_digits", digits(), 16'h0200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
